// File: rtl/and_nand_nor_32.sv
// and_nand_nor_32: registered bitwise AND/NAND/NOR unit with reserved-op flag.
// Define AND_NAND_NOR_TRISTATE_EN to release out to Z whenever out_valid is low.
module and_nand_nor_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             op_err,
  output logic             zero
);
  logic [WIDTH-1:0] res, nxt;
  always_comb nxt = op == 2'b00 ? a & b : op == 2'b01 ? ~(a & b) : op == 2'b10 ? ~(a | b) : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      res       <= '0;
      out_valid <= 1'b0;
      op_err    <= 1'b0;
    end else begin
      out_valid <= in_valid && op != 2'b11;
      if (in_valid) begin
        res    <= nxt;
        op_err <= op == 2'b11;
      end
    end
  assign zero = out_valid && res == '0;
`ifdef AND_NAND_NOR_TRISTATE_EN
  assign out = out_valid ? res : {WIDTH{1'bz}};
`else
  assign out = res;
`endif
endmodule

// File: tb/tb_and_nand_nor_32.sv
// tb_and_nand_nor_32: directed vectors with hand-computed results for and_nand_nor_32.
module tb_and_nand_nor_32;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0;
  logic [31:0] out;
  logic        out_valid, op_err, zero;
  int errors = 0;
  int checks = 0;

  and_nand_nor_32 #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .op(op), .a(a), .b(b),
    .out(out), .out_valid(out_valid), .op_err(op_err), .zero(zero)
  );

  always #5 clk = ~clk;

  // What out must read given the expected valid flag and register contents.
  function automatic logic [31:0] exp_out(input logic v, input logic [31:0] val);
`ifdef AND_NAND_NOR_TRISTATE_EN
    return v ? val : 32'hzzzz_zzzz;
`else
    return val;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] o, input logic v, input logic e, input logic z);
    chk({tag, ".out"}, out, o);
    chk({tag, ".out_valid"}, {31'b0, out_valid}, {31'b0, v});
    chk({tag, ".op_err"}, {31'b0, op_err}, {31'b0, e});
    chk({tag, ".zero"}, {31'b0, zero}, {31'b0, z});
  endtask

  task automatic step(input logic v, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    in_valid = v; op = o; a = x; b = y;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12;
    chk_all("por", exp_out(1'b0, 32'h0), 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 2'b00, 32'hF0F0_F0F0, 32'hFF00_FF00);
    chk_all("and", 32'hF000_F000, 1'b1, 1'b0, 1'b0);
    step(1'b1, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk_all("nand_ones", 32'h0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 2'b01, 32'h1234_5678, 32'h0);
    chk_all("nand_zero_b", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    step(1'b1, 2'b10, 32'h0, 32'h0);
    chk_all("nor_zeros", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    step(1'b1, 2'b10, 32'hAAAA_AAAA, 32'h5555_5555);
    chk_all("nor_alt", 32'h0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 2'b00, 32'h1234_5678, 32'hFFFF_0000);
    chk_all("and_pre_rsv", 32'h1234_0000, 1'b1, 1'b0, 1'b0);
    step(1'b1, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk_all("reserved", exp_out(1'b0, 32'h0), 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      chk_all("idle_after_rsv", exp_out(1'b0, 32'h0), 1'b0, 1'b1, 1'b0);
    end
    step(1'b1, 2'b00, 32'hFFFF_FFFF, 32'h0F0F_0F0F);
    chk_all("and_clears_err", 32'h0F0F_0F0F, 1'b1, 1'b0, 1'b0);
    step(1'b0, 2'b10, 32'h0, 32'h0);
    chk_all("hold", exp_out(1'b0, 32'h0F0F_0F0F), 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'b00, 32'h0000_FFFF, 32'h00FF_00FF);
    chk_all("stream_and", 32'h0000_00FF, 1'b1, 1'b0, 1'b0);
    step(1'b1, 2'b01, 32'h0000_FFFF, 32'h00FF_00FF);
    chk_all("stream_nand", 32'hFFFF_FF00, 1'b1, 1'b0, 1'b0);
    step(1'b1, 2'b10, 32'h0000_FFFF, 32'h00FF_00FF);
    chk_all("stream_nor", 32'hFF00_0000, 1'b1, 1'b0, 1'b0);
    step(1'b1, 2'b11, 32'h0, 32'h0);
    chk_all("rsv_pre_reset", exp_out(1'b0, 32'h0), 1'b0, 1'b1, 1'b0);
    step(1'b1, 2'b10, 32'h0, 32'h0);
    chk_all("nor_pre_reset", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b1; op = 2'b11; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    chk_all("rsv_again", exp_out(1'b0, 32'h0), 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    in_valid = 1'b1; op = 2'b00;
    @(posedge clk);
    #1;
    chk_all("and_ff", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_reset", exp_out(1'b0, 32'h0), 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk_all("reset_priority", exp_out(1'b0, 32'h0), 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all("first_capture", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
